multi_cycle_controller: RTL

Main control FSM for the multi-cycle MIPS CPU: sequences the shared datapath (PC, IR, register file, ALU, unified memory) through fetch, decode, execute, memory and write-back states. It sits beside the datapath inside the top-level CPU, consumes the instruction fields, ALU `Zero` and a memory-ready handshake, and drives every datapath enable and mux select.

---
 rtl/multi_cycle_controller_if.sv | 34 +++
 rtl/multi_cycle_controller.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/multi_cycle_controller_if.sv
// multi_cycle_controller_if: instruction fields, status and datapath controls of the multi-cycle MIPS controller
interface multi_cycle_controller_if;
  logic [5:0] OpCode;
  logic [5:0] Funct;
  logic       Zero;
  logic       mem_ready;
  logic       PCWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic       MemWrite;
  logic       MemRead;
  logic       IorD;
  logic [1:0] RegDst;
  logic [1:0] MemtoReg;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUOp;
  logic [1:0] PCSource;
  logic       ExtOp;
  logic       LuiOp;
  logic [3:0] state;
  logic       instr_done;
  logic       illegal;
  modport master (
    input  OpCode, Funct, Zero, mem_ready,
    output PCWrite, IRWrite, RegWrite, MemWrite, MemRead, IorD, RegDst, MemtoReg,
           ALUSrcA, ALUSrcB, ALUOp, PCSource, ExtOp, LuiOp, state, instr_done, illegal
  );
  modport slave (
    output OpCode, Funct, Zero, mem_ready,
    input  PCWrite, IRWrite, RegWrite, MemWrite, MemRead, IorD, RegDst, MemtoReg,
           ALUSrcA, ALUSrcB, ALUOp, PCSource, ExtOp, LuiOp, state, instr_done, illegal
  );
endinterface

// File: rtl/multi_cycle_controller.sv
// multi_cycle_controller: main control FSM sequencing the multi-cycle MIPS datapath
module multi_cycle_controller (
  input logic clk,
  input logic reset,
  multi_cycle_controller_if.master bus
);
  typedef enum logic [3:0] {
    S_IF = 4'd0, S_ID = 4'd1, S_MADDR = 4'd2, S_MRD = 4'd3, S_MWB = 4'd4, S_MWR = 4'd5,
    S_REX = 4'd6, S_RWB = 4'd7, S_IEX = 4'd8, S_IWB = 4'd9, S_BR = 4'd10, S_JMP = 4'd11
  } state_t;
  state_t st, nx;
  logic [5:0] op_q, fn_q;
  logic rfn_ok, id_ok;
  // state register; opcode and funct captured while decoding
  always_ff @(posedge clk) begin
    if (!reset) begin
      st <= S_IF;
      op_q <= '0;
      fn_q <= '0;
    end else begin
      st <= nx;
      if (st == S_ID) begin
        op_q <= bus.OpCode;
        fn_q <= bus.Funct;
      end
    end
  end
  // legality of the live instruction fields seen in ID
  always_comb begin
    rfn_ok = bus.Funct inside {6'h00, 6'h02, 6'h03, 6'h08, 6'h09, [6'h20:6'h27], 6'h2A, 6'h2B};
    id_ok = bus.OpCode inside {6'h23, 6'h2B, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0F,
                               6'h04, 6'h05, 6'h02, 6'h03} || (bus.OpCode == 6'h00 && rfn_ok);
  end
  // next state and all datapath controls; everything is forced low during reset
  always_comb begin
    nx = S_IF;
    bus.PCWrite = 1'b0;
    bus.IRWrite = 1'b0;
    bus.RegWrite = 1'b0;
    bus.MemWrite = 1'b0;
    bus.MemRead = 1'b0;
    bus.IorD = 1'b0;
    bus.RegDst = 2'd0;
    bus.MemtoReg = 2'd0;
    bus.ALUSrcA = 2'd0;
    bus.ALUSrcB = 2'd0;
    bus.ALUOp = 3'd0;
    bus.PCSource = 2'd0;
    bus.ExtOp = 1'b0;
    bus.LuiOp = 1'b0;
    bus.instr_done = 1'b0;
    bus.illegal = 1'b0;
    bus.state = reset ? st : S_IF;
    if (reset) begin
      case (st)
        S_IF: begin
          bus.MemRead = 1'b1;
          bus.ALUSrcB = 2'd1;
          bus.IRWrite = bus.mem_ready;
          bus.PCWrite = bus.mem_ready;
          nx = bus.mem_ready ? S_ID : S_IF;
        end
        S_ID: begin
          bus.ALUSrcB = 2'd3;
          bus.ExtOp = 1'b1;
          bus.illegal = !id_ok;
          bus.instr_done = !id_ok;
          nx = !id_ok ? S_IF :
               bus.OpCode inside {6'h23, 6'h2B} ? S_MADDR :
               bus.OpCode == 6'h00 ? S_REX :
               bus.OpCode inside {6'h04, 6'h05} ? S_BR :
               bus.OpCode inside {6'h02, 6'h03} ? S_JMP : S_IEX;
        end
        S_MADDR: begin
          bus.ALUSrcA = 2'd1;
          bus.ALUSrcB = 2'd2;
          bus.ExtOp = 1'b1;
          nx = op_q == 6'h23 ? S_MRD : S_MWR;
        end
        S_MRD: begin
          bus.MemRead = 1'b1;
          bus.IorD = 1'b1;
          nx = bus.mem_ready ? S_MWB : S_MRD;
        end
        S_MWB: begin
          bus.RegWrite = 1'b1;
          bus.MemtoReg = 2'd1;
          bus.instr_done = 1'b1;
        end
        S_MWR: begin
          bus.MemWrite = 1'b1;
          bus.IorD = 1'b1;
          bus.instr_done = bus.mem_ready;
          nx = bus.mem_ready ? S_IF : S_MWR;
        end
        S_REX: begin
          bus.ALUSrcA = fn_q inside {6'h00, 6'h02, 6'h03} ? 2'd2 : 2'd1;
          bus.ALUOp = 3'd2;
          bus.PCWrite = fn_q inside {6'h08, 6'h09};
          bus.PCSource = fn_q inside {6'h08, 6'h09} ? 2'd3 : 2'd0;
          bus.instr_done = fn_q inside {6'h08, 6'h09};
          bus.RegWrite = fn_q == 6'h09;
          bus.RegDst = fn_q == 6'h09 ? 2'd1 : 2'd0;
          bus.MemtoReg = fn_q == 6'h09 ? 2'd2 : 2'd0;
          nx = fn_q inside {6'h08, 6'h09} ? S_IF : S_RWB;
        end
        S_RWB: begin
          bus.RegWrite = 1'b1;
          bus.RegDst = 2'd1;
          bus.instr_done = 1'b1;
        end
        S_IEX: begin
          bus.ALUSrcA = 2'd1;
          bus.ALUSrcB = 2'd2;
          bus.ALUOp = op_q == 6'h0A ? 3'd6 : op_q == 6'h0B ? 3'd7 :
                      op_q == 6'h0C ? 3'd3 : op_q == 6'h0D ? 3'd4 : 3'd0;
          bus.ExtOp = op_q inside {6'h08, 6'h09, 6'h0A, 6'h0B};
          bus.LuiOp = op_q == 6'h0F;
          nx = S_IWB;
        end
        S_IWB: begin
          bus.RegWrite = 1'b1;
          bus.instr_done = 1'b1;
        end
        S_BR: begin
          bus.ALUSrcA = 2'd1;
          bus.ALUOp = 3'd1;
          bus.PCSource = 2'd1;
          bus.PCWrite = op_q == 6'h04 ? bus.Zero : !bus.Zero;
          bus.instr_done = 1'b1;
        end
        S_JMP: begin
          bus.PCWrite = 1'b1;
          bus.PCSource = 2'd2;
          bus.instr_done = 1'b1;
          bus.RegWrite = op_q == 6'h03;
          bus.RegDst = op_q == 6'h03 ? 2'd2 : 2'd0;
          bus.MemtoReg = op_q == 6'h03 ? 2'd2 : 2'd0;
        end
        default: nx = S_IF;
      endcase
    end
  end
endmodule
